// File: rtl/seven_segment_scan_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs,
// blank levels and digit count.
package seven_segment_scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Patterns are written as {g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Bit i set when nibbles i..3 are all zero; the rightmost digit is never blanked.
  function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [4*NUM_DIGITS-1:0] value);
    logic [NUM_DIGITS-1:0] mask;
    mask    = '0;
    mask[3] = (value[15:12] == 4'h0);
    mask[2] = (value[15:8]  == 8'h00);
    mask[1] = (value[15:4]  == 12'h000);
    return mask;
  endfunction

endpackage

// File: rtl/seven_segment_scan_hex_to_seven_segment.sv
// Purely combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seven_segment
  import seven_segment_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame input snapshot.
// Optional leading-zero blanking: define SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
module seven_segment_scan
  import seven_segment_scan_pkg::*;
#(
  parameter int DIGIT_PERIOD = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                      mclk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   number,
  input  logic [NUM_DIGITS-1:0]     dot,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int CNT_W = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   number_sh_q, number_sh_d;
  logic [NUM_DIGITS-1:0]     dot_sh_q, dot_sh_d;
  logic [NUM_DIGITS-1:0]     en_sh_q, en_sh_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_start_q, frame_start_d;

  logic                      snapshot;
  logic [3:0]                nibble;
  logic [6:0]                seg_pattern;
  logic [NUM_DIGITS-1:0]     lz_blank;
  logic                      shown;

  hex_to_seven_segment u_decode (
    .nibble (nibble),
    .seg_n  (seg_pattern)
  );

  // Display decisions use the next shadow value so the snapshot cycle itself
  // already reflects the new frame's content.
  always_comb begin
    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    idx_d         = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    snapshot      = (cnt_q == '0) && (idx_q == 2'd0);
    number_sh_d   = snapshot ? number   : number_sh_q;
    dot_sh_d      = snapshot ? dot      : dot_sh_q;
    en_sh_d       = snapshot ? digit_en : en_sh_q;
    frame_start_d = snapshot;
    nibble        = number_sh_d[{idx_q, 2'b00} +: 4];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    lz_blank      = leading_zero_mask(number_sh_d);
`else
    lz_blank      = '0;
`endif
    shown         = en_sh_d[idx_q] && !lz_blank[idx_q];

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((cnt_q >= BLANK_END) && shown) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_pattern;
      dp_d  = ~dot_sh_d[idx_q];
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      number_sh_q   <= '0;
      dot_sh_q      <= '0;
      en_sh_q       <= '0;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      number_sh_q   <= number_sh_d;
      dot_sh_q      <= dot_sh_d;
      en_sh_q       <= en_sh_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display, directly downstream of the top-level logic that currently ties `seg`/`dp`/`an` to constants. The block takes a 16-bit hex value, per-digit decimal points and a digit-enable mask, and scans the four digits one at a time. Each scan slot starts with an anti-ghosting blank interval. Inputs are snapshotted once per frame so a frame never shows a mix of old and new values.

## Interface
- `DIGIT_PERIOD`, 50000: clock cycles per digit slot (1 ms at 50 MHz); legal range ≥ 2.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < DIGIT_PERIOD.
- `mclk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `number` in 16: hex value; `number[3:0]` is digit 0 (rightmost, `an[0]`).
- `dot` in 4: `dot[i]` lights the decimal point of digit i.
- `digit_en` in 4: `digit_en[i]=0` keeps digit i dark.
- `seg` out 7: active-low segments, `seg[0]`=a … `seg[6]`=g.
- `dp` out 1: active-low decimal point.
- `an` out 4: active-low anodes, at most one low at any time.
- `frame_start` out 1: one-cycle pulse at the start of digit 0's slot.

## Operation
- Slot counter `cnt` counts 0..DIGIT_PERIOD-1 and wraps. Digit index `idx` (2 bits) increments on each wrap, 3→0.
- Snapshot: on every cycle with `cnt==0 && idx==0`, including the first cycle after reset, `number`, `dot` and `digit_en` are latched into shadow registers. Display content comes only from the shadow registers.
- Per-slot output rule:
  - `cnt < BLANK_CYCLES`: `an=4'b1111`, `seg=7'b1111111`, `dp=1`.
  - Otherwise, if digit idx is shown: `an=~(4'b0001<<idx)`, `seg=decode(shadow nibble idx)`, `dp=~shadow_dot[idx]`.
  - Otherwise (digit not shown): blank values as above.
- Decode is hex 0–F with standard glyphs. Examples: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110.
- All outputs are registered.
- Reset values: `an=4'b1111`, `seg=7'b1111111`, `dp=1`, `frame_start=0`; `cnt=0`, `idx=0`; shadow registers cleared to zero, so `digit_en` reads as 0.
- Reset asserted mid-slot: outputs go blank on the next edge. Scanning restarts at digit 0, `cnt=0`, and a fresh snapshot is taken.
- Input changes mid-frame have no visible effect until the next snapshot.

## Timing
- Output latency: one cycle from counter state to pins. The combinational decision made at `(cnt, idx)` appears on the pins in the following cycle.
- `frame_start` is high during the cycle after the snapshot cycle, i.e. the first output cycle of digit 0's slot.
- Frame length is 4·DIGIT_PERIOD cycles. Each digit is lit for DIGIT_PERIOD−BLANK_CYCLES cycles per frame.
- With BLANK_CYCLES=0, anodes switch directly from one digit to the next with no dark cycle.
- With all `digit_en=0`, `an` stays 4'b1111 continuously, while `frame_start` keeps pulsing.

## Configuration
- `SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN` defined:
  - Digit i (i≥1) is additionally blanked when shadow nibbles i..3 are all zero.
  - Digit 0 is never blanked by this rule.
  - The rule is evaluated on the shadow registers, once per frame.
- Undefined: every enabled digit is shown, including leading zeros.

## Structure
- Shared package or include holds:
  - the 16 segment-pattern constants;
  - the blank constants (`SEG_OFF=7'b1111111`, `AN_OFF=4'b1111`);
  - the digit count (4).
- Sub-module `hex_to_seven_segment`: purely combinational, nibble in, active-low 7-bit pattern out.
- Counters, snapshot logic and output registers live in `seven_segment_scan`.

## Test plan
All scenarios use DIGIT_PERIOD=8, BLANK_CYCLES=2.
- Reset: hold `reset` 3 cycles → `an=1111`, `seg=1111111`, `dp=1`, `frame_start=0` throughout. After release, the first `frame_start` pulse arrives 1 cycle later.
- Scan order: `number=16'h1234`, `digit_en=1111`, `dot=0000`, per slot:
  - `an=1110` with `seg`=pattern 4 for 6 cycles, after 2 blank cycles;
  - then `1101`/3, `1011`/2, `0111`/1;
  - frame repeats every 32 cycles.
- Snapshot isolation: change `number` 16'h1234→16'hABCD in the middle of digit 2's slot → the rest of that frame still shows 1,2; A–D appear only after the next `frame_start`.
- Mask and dots: `digit_en=0101`, `dot=0100`, `number=16'h8888` → only `an=1110` and `an=1011` ever go low; `dp=0` only while `an=1011`.
- Leading zeros, `number=16'h0050`, `digit_en=1111`:
  - with macro: digits 3 and 2 stay dark, digits 1 and 0 show 5 and 0;
  - without macro: all four digits are shown.
- Reset mid-scan: assert `reset` for 1 cycle during digit 2's lit phase → blank on the next edge. Scan resumes at `an=1110` after 2 blank cycles, with a fresh snapshot.
